// File: rtl/stack_ctrl.sv
// Call/return/interrupt sequencer driving an external hardware return-address stack.
// Latency: request acked in the accept cycle, stack strobe one cycle later, idle again three cycles after accept.
// Backpressure: level requests wait while busy or while losing arbitration; optional overflow/underflow guard via STACK_GUARD_EN.
module stack_ctrl #(
    parameter int NADDR = 7,
    parameter int DEPTH = 3,
    parameter int NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             call,
    input  logic             ret,
    input  logic             irq_req,
    input  logic             iret,
    input  logic [NBITS-1:0] call_pc,
    input  logic [NBITS-1:0] irq_pc,
    output logic             call_ack,
    output logic             ret_ack,
    output logic             irq_ack,
    output logic             iret_ack,
    output logic             st_push,
    output logic             st_pop,
    output logic [NBITS-1:0] st_in,
    input  logic [NBITS-1:0] st_out,
    output logic             pc_load,
    output logic [NBITS-1:0] pc_out,
    output logic             busy,
    output logic [NADDR-1:0] level,
    output logic             full,
    output logic             empty,
    output logic             irq_active,
    output logic             err_ovf,
    output logic             err_unf
);

    typedef enum logic [1:0] {IDLE, ACT, SETTLE} state_t;

    state_t           state;
    state_t           state_nxt;
    logic             op_pop;     // operation in flight is a pop (ret/iret)
    logic [NBITS-1:0] push_pc;    // address captured at push acceptance
    logic             accept;
    logic             blk_push;
    logic             blk_pop;

    assign empty = (level == '0);
    assign full  = (level == NADDR'(DEPTH));
    assign busy  = (state != IDLE);
    assign st_in = push_pc;

`ifdef STACK_GUARD_EN
    assign blk_push = full;
    assign blk_pop  = empty;
`else
    assign blk_push = 1'b0;
    assign blk_pop  = 1'b0;
`endif

    // Stack strobes only in ACT; a reset cycle aborts whatever is in flight.
    assign st_push = (state == ACT) && !op_pop && !blk_push && !rst;
    assign st_pop  = (state == ACT) &&  op_pop && !blk_pop  && !rst;
    assign pc_load = (state == SETTLE) && op_pop && !rst;

    // Fixed-priority arbitration in IDLE and next-state selection.
    always_comb begin
        irq_ack   = 1'b0;
        iret_ack  = 1'b0;
        call_ack  = 1'b0;
        ret_ack   = 1'b0;
        state_nxt = state;
        if (state == IDLE && !rst) begin
            if (irq_req && !irq_active)
                irq_ack = 1'b1;
            else if (iret && irq_active)
                iret_ack = 1'b1;
            else if (call)
                call_ack = 1'b1;
            else if (ret)
                ret_ack = 1'b1;
        end
        case (state)
            IDLE:    if (accept) state_nxt = ACT;
            ACT:     state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = irq_ack | iret_ack | call_ack | ret_ack;

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Capture the accepted operation and the address to push.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_pop  <= 1'b0;
            push_pc <= '0;
        end else if (accept) begin
            op_pop <= ret_ack | iret_ack;
            if (irq_ack)
                push_pc <= irq_pc;
            else if (call_ack)
                push_pc <= call_pc;
        end
    end

    // Occupancy follows the actual stack strobes, so a guarded op keeps level.
    always_ff @(posedge clk) begin
        if (rst)
            level <= '0;
        else if (st_push)
            level <= level + 1'b1;
        else if (st_pop)
            level <= level - 1'b1;
    end

    // Returned address is latched during ACT and held until the next pop.
    always_ff @(posedge clk) begin
        if (rst)
            pc_out <= '0;
        else if (state == ACT && op_pop)
            pc_out <= blk_pop ? '0 : st_out;
    end

    // Interrupt nesting flag: one level of interrupt only.
    always_ff @(posedge clk) begin
        if (rst)
            irq_active <= 1'b0;
        else if (irq_ack)
            irq_active <= 1'b1;
        else if (iret_ack)
            irq_active <= 1'b0;
    end

`ifdef STACK_GUARD_EN
    // Sticky misuse flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else if (state == ACT) begin
            if (!op_pop && blk_push)
                err_ovf <= 1'b1;
            if (op_pop && blk_pop)
                err_unf <= 1'b1;
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter NADDR, default 7: width of the occupancy counter; SHALL equal the attached stack's NADDR.
REQ-002 Parameter DEPTH, default 3: stack entries; SHALL equal the attached stack's DEPTH.
REQ-003 Parameter NBITS, default 8: return-address width.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 call, ret, irq_req, iret  in  1 each  level requests, held until their ack.
REQ-007 call_pc, irq_pc  in  NBITS each  address to save on call / interrupt entry.
REQ-008 call_ack, ret_ack, irq_ack, iret_ack  out  1 each  one-cycle acceptance pulses.
REQ-009 st_push, st_pop  out  1 each  drive stack push/pop; st_in  out  NBITS  stack write data; st_out  in  NBITS  stack read data.
REQ-010 pc_load  out  1  one-cycle pulse: pc_out valid; pc_out  out  NBITS  returned address.
REQ-011 busy  out  1; level  out  NADDR; full, empty, irq_active  out  1 each; err_ovf, err_unf  out  1 each.

Function
REQ-012 FSM states IDLE, ACT, SETTLE; busy SHALL be 1 exactly when state is not IDLE.
REQ-013 Requests SHALL be sampled only in IDLE; fixed priority irq_req > iret > call > ret; one accepted per cycle T, its ack pulsing in T.
REQ-014 irq_req SHALL be eligible only while irq_active=0; iret only while irq_active=1; an ineligible request is never acked.
REQ-015 Push op (call/irq_req), accepted at T: ACT at T+1 with st_push=1 and st_in = captured call_pc/irq_pc; SETTLE at T+2; IDLE at T+3; level increments at end of T+1.
REQ-016 Pop op (ret/iret), accepted at T: ACT at T+1 with st_pop=1 and pc_out <= st_out; SETTLE at T+2 with pc_load=1; IDLE at T+3; level decrements at end of T+1.
REQ-017 st_push and st_pop SHALL never be asserted together and only in ACT.
REQ-018 irq_active SHALL set at end of irq_req-accept cycle and clear at end of iret-accept cycle.
REQ-019 empty = (level==0); full = (level==DEPTH); combinational from level.
REQ-020 pc_out SHALL hold its value between pc_load pulses.
REQ-021 Requests asserted while busy SHALL wait; losing requests in a tie SHALL wait, not drop.

Reset
REQ-022 rst SHALL force state IDLE, level 0, irq_active 0, err_ovf 0, err_unf 0, pc_out 0, and all acks, st_push, st_pop, pc_load, busy to 0 in the following cycle.
REQ-023 rst during ACT or SETTLE SHALL abort the operation; no st_push/st_pop/pc_load pulse follows; the stack's rst is driven from the same rst.

Configuration
REQ-024 Macro STACK_GUARD_EN defined: push accepted while full SHALL be acked, suppress st_push, keep level, set sticky err_ovf; pop accepted while empty SHALL be acked, suppress st_pop, keep level, pulse pc_load with pc_out=0, set sticky err_unf; errors clear only on rst.
REQ-025 STACK_GUARD_EN undefined: no checks; err_ovf, err_unf tied to 0; level wraps modulo 2^NADDR; stack contents undefined after overflow/underflow.

Verification (NADDR=7, DEPTH=3, NBITS=8)
REQ-026 call with call_pc=0x12, then ret -> st_push at T+1 with st_in=0x12; later pc_load with pc_out=0x12; level 0->1->0.
REQ-027 calls 0x01,0x02,0x03 then three rets -> pc_out 0x03,0x02,0x01 in order; full=1 after third call; empty=1 at end.
REQ-028 call and irq_req asserted same cycle (irq_pc=0x40, call_pc=0x20) -> irq_ack first, call_ack at first IDLE after; irq_active=1; iret returns 0x20 is NOT allowed before ret; ret returns 0x20, iret returns 0x40.
REQ-029 STACK_GUARD_EN: fourth call with full stack -> call_ack, no st_push, err_ovf=1, level stays 3; ret on empty -> pc_load, pc_out=0, err_unf=1.
REQ-030 rst asserted during ACT of a push -> no st_push following, level 0, busy 0, next cycle IDLE.
REQ-031 iret with irq_active=0 held 10 cycles -> no iret_ack, no st_pop, state stays IDLE.
